// File: rtl/regbank_wb_arbiter.sv
// Writeback arbiter for a register bank fed by an ALU and a load unit, with a
// pending-write scoreboard used for decode hazard detection.
module regbank_wb_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        issueValid,
   input  logic [4:0]  issueDest,
   input  logic [4:0]  rsAddr,
   input  logic [4:0]  rtAddr,
   output logic        hazard,
   input  logic        aluValid,
   output logic        aluReady,
   input  logic [4:0]  aluReg,
   input  logic [31:0] aluData,
   input  logic        memValid,
   output logic        memReady,
   input  logic [4:0]  memReg,
   input  logic [31:0] memData,
   output logic        regWrite,
   output logic [4:0]  writeReg,
   output logic [31:0] writeData,
   output logic [31:0] busy,
   output logic [15:0] conflictCount
);

   typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_t;

   grant_t      last_grant;
   logic        grant_alu;
   logic        grant_mem;
   logic        transfer;
   logic [4:0]  sel_reg;
   logic [31:0] sel_data;
   logic [31:0] busy_next;

   // On a conflict the source that did not win last time gets the port.
   always_comb begin
      grant_alu = 1'b0;
      grant_mem = 1'b0;
      if (!rst) begin
         if (aluValid && memValid) begin
            grant_alu = (last_grant == GRANT_MEM);
            grant_mem = (last_grant == GRANT_ALU);
         end else begin
            grant_alu = aluValid;
            grant_mem = memValid;
         end
      end
   end

   always_comb begin
      aluReady = grant_alu;
      memReady = grant_mem;
      transfer = grant_alu | grant_mem;
      sel_reg  = grant_mem ? memReg  : aluReg;
      sel_data = grant_mem ? memData : aluData;
   end

   // Clear from the retiring write first so a same-edge issue wins.
   always_comb begin
      busy_next = busy;
      if (regWrite)
         busy_next[writeReg] = 1'b0;
      if (issueValid && (issueDest != 5'd0))
         busy_next[issueDest] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_comb begin
      hazard = busy[rsAddr] | busy[rtAddr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regWrite      <= 1'b0;
         writeReg      <= '0;
         writeData     <= '0;
         busy          <= '0;
         last_grant    <= GRANT_MEM;
         conflictCount <= '0;
      end else begin
         busy     <= busy_next;
         regWrite <= transfer && (sel_reg != 5'd0);
         if (transfer) begin
            writeReg   <= sel_reg;
            writeData  <= sel_data;
            last_grant <= grant_mem ? GRANT_MEM : GRANT_ALU;
         end
         if (aluValid && memValid && (conflictCount != '1))
            conflictCount <= conflictCount + 16'd1;
      end
   end

endmodule

// File: doc/regbank_wb_arbiter.md
REGBANK_WB_ARBITER -- requirements
Module: regbank_wb_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous active-high reset.
REQ-004 SHALL have port issueValid  in  1  an instruction with a register destination issues this cycle.
REQ-005 SHALL have port issueDest  in  5  destination register of the issuing instruction.
REQ-006 SHALL have port rsAddr  in  5  first source register of the decoding instruction.
REQ-007 SHALL have port rtAddr  in  5  second source register of the decoding instruction.
REQ-008 SHALL have port hazard  out  1  a source register has a pending write.
REQ-009 SHALL have port aluValid  in  1  ALU writeback request.
REQ-010 SHALL have port aluReady  out  1  ALU request accepted this cycle.
REQ-011 SHALL have port aluReg  in  5  ALU destination register.
REQ-012 SHALL have port aluData  in  32  ALU result.
REQ-013 SHALL have ports memValid/memReady/memReg/memData, with the same directions, widths and meanings for the load path.
REQ-014 SHALL have port regWrite  out  1  register bank write enable.
REQ-015 SHALL have port writeReg  out  5  register bank write address.
REQ-016 SHALL have port writeData  out  32  register bank write data.
REQ-017 SHALL have port busy  out  32  scoreboard; bit i = register i has a pending write.
REQ-018 SHALL have port conflictCount  out  16  number of cycles in which both sources requested.

Function
REQ-019 SHALL complete a transfer on a source when its valid and ready are both 1 on the same clock edge.
REQ-020 SHALL grant at most one source per cycle.
- With only one source valid, that source SHALL be granted.
- With both valid, the source not granted most recently SHALL be granted (round-robin).
REQ-021 SHALL hold a 1-bit lastGrant register (0 = ALU, 1 = MEM), updated only on a completed transfer.
REQ-022 SHALL derive aluReady and memReady combinationally from the valids and lastGrant, and SHALL NOT assert ready without the corresponding valid.
REQ-023 SHALL register the granted source's reg/data into writeReg/writeData on the transfer edge; regWrite SHALL be 1 in the following cycle only (latency 1).
- writeReg/writeData SHALL hold their last value when no transfer occurs.
REQ-024 SHALL accept a transfer to register 0 (ready asserted, lastGrant updated) but SHALL keep regWrite 0 for it.
REQ-025 SHALL set busy[issueDest] on the edge where issueValid=1 and issueDest≠0.
REQ-026 SHALL clear busy[writeReg] on the edge ending a cycle in which regWrite=1.
REQ-027 SHALL give set priority over clear when both target the same register on the same edge.
REQ-028 SHALL keep busy[0] at 0 at all times.
REQ-029 SHALL keep busy as a single bit per register; a second issue to a busy register leaves it at 1.
REQ-030 SHALL compute hazard = busy[rsAddr] | busy[rtAddr] combinationally from the current busy state; address 0 never yields a hazard.
REQ-031 SHALL increment conflictCount on each edge where aluValid=1 and memValid=1, saturating at 0xFFFF.

Reset
REQ-032 SHALL, on a rising edge with rst=1, load regWrite=0, writeReg=0, writeData=0, busy=0, lastGrant=1 (ALU wins the first conflict) and conflictCount=0.
REQ-033 SHALL discard any transfer or issue presented in a reset cycle; no state changes other than the reset values.
REQ-034 SHALL drive aluReady and memReady to 0 while rst=1.

Verification
REQ-035 SHALL verify single source: aluValid=1, aluReg=5, aluData=0x0000ABCD for 1 cycle -> aluReady=1 that cycle; next cycle regWrite=1, writeReg=5, writeData=0x0000ABCD; the cycle after, regWrite=0.
REQ-036 SHALL verify conflict: both valid for 3 cycles after reset -> grants ALU, MEM, ALU; conflictCount=3; three consecutive regWrite pulses.
REQ-037 SHALL verify scoreboard: issue dest 8 -> busy=0x00000100; rsAddr=8 gives hazard=1; MEM writes reg 8 -> busy[8] clears the edge after its regWrite cycle and hazard=0.
REQ-038 SHALL verify the set/clear collision: regWrite to reg 3 in the same cycle as an issue to dest 3 -> busy[3] remains 1.
REQ-039 SHALL verify register 0: issue dest 0 plus an ALU write to reg 0 -> busy=0, aluReady=1, regWrite stays 0.
REQ-040 SHALL verify reset mid-operation: rst=1 while both sources are valid and busy=0x0000FF00 -> next cycle busy=0, regWrite=0, conflictCount=0, and the first post-reset conflict grants ALU.
